// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// One shift-and-correct step per clock; start/busy/done handshake, invalid digits flagged.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state, state_nx;
    logic [SR_W-1:0]  sr, sr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             busy_nx, done_nx, err_nx;
    logic [BIN_W-1:0] bin_nx;

    logic             bcd_bad_c;
    logic [SR_W-1:0]  sr_step_c;
    logic [3:0]       dig_c;

    // Flag any input digit above 9
    always_comb begin
        bcd_bad_c = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bcd_bad_c = 1'b1;
            end
        end
    end

    // One iteration: logical right shift, then subtract 3 from every bcd digit >= 8
    always_comb begin
        sr_step_c = sr >> 1;
        dig_c     = 4'd0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            dig_c = sr_step_c[BIN_W + 4*d +: 4];
            if (dig_c >= 4'd8) begin
                sr_step_c[BIN_W + 4*d +: 4] = dig_c - 4'd3;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        bin_nx   = bin_out;
        err_nx   = err;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (bcd_bad_c) begin
                        bin_nx   = '0;
                        err_nx   = 1'b1;
                        done_nx  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        sr_nx    = {bcd_in, BIN_W'(0)};
                        cnt_nx   = '0;
                        state_nx = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                sr_nx  = sr_step_c;
                cnt_nx = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    bin_nx   = sr_step_c[BIN_W-1:0];
                    err_nx   = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        busy_nx = (state_nx != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sr      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            cnt     <= cnt_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            bin_out <= bin_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (DIGITS=2, BIN_W=7).
module tb_bcd_to_bin_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] bcd_in;
    logic       busy;
    logic       done;
    logic [6:0] bin_out;
    logic       err;

    int n_checks = 0;
    int n_err    = 0;

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch one conversion from IDLE and check the whole handshake.
    // exp_edges counts the accepting edge, so valid input expects 8 and invalid 1.
    task automatic convert(input logic [7:0] bcd, input int exp_bin, input logic exp_err,
                           input int exp_edges, input string tag);
        int lat;
        start  = 1'b1;
        bcd_in = bcd;
        tick();
        start  = 1'b0;
        chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        chk({tag, " done_edges"}, 32'(lat + 1), 32'(exp_edges));
        chk({tag, " bin_out"}, 32'(bin_out), 32'(exp_bin));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        tick();
        chk({tag, " done_low_after"}, 32'(done), 32'd0);
        chk({tag, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int         c;
        int         nres;
        int         last_done;
        int         toggle;
        int         ndone;
        logic       prev_busy;
        logic [3:0] tt;
        logic [3:0] oo;

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 8'h00;
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bin_out", 32'(bin_out), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Basic conversion and boundaries
        convert(8'h45, 45, 1'b0, 8, "bcd45");
        convert(8'h00, 0,  1'b0, 8, "bcd00");
        convert(8'h99, 99, 1'b0, 8, "bcd99");
        convert(8'h18, 18, 1'b0, 8, "bcd18");

        // Full sweep of legal inputs against tens*10+ones
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                tt = 4'(t);
                oo = 4'(o);
                convert({tt, oo}, t * 10 + o, 1'b0, 8, "sweep");
            end
        end

        // Invalid digits, then recovery
        convert(8'hA5, 0, 1'b1, 1, "badA5");
        convert(8'h3F, 0, 1'b1, 1, "bad3F");
        convert(8'h07, 7, 1'b0, 8, "bcd07");

        // Busy protection: starts during SHIFT and during DONE are ignored
        start  = 1'b1;
        bcd_in = 8'h21;
        tick();
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) begin
                start  = 1'b1;
                bcd_in = 8'h64;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("busyprot done", 32'(done), 32'd1);
        chk("busyprot bin_out", 32'(bin_out), 32'd21);
        start  = 1'b1;
        bcd_in = 8'h64;
        tick();
        start = 1'b0;
        chk("busyprot done_cleared", 32'(done), 32'd0);
        chk("busyprot idle", 32'(busy), 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("busyprot extra_done", 32'(ndone), 32'd0);
        chk("busyprot bin_hold", 32'(bin_out), 32'd21);

        // Continuous start with alternating operands
        start     = 1'b1;
        bcd_in    = 8'h12;
        toggle    = 0;
        nres      = 0;
        last_done = 0;
        c         = 0;
        while (nres < 3 && c < 60) begin
            prev_busy = busy;
            tick();
            c++;
            if (!prev_busy && busy) begin
                toggle ^= 1;
                bcd_in = (toggle != 0) ? 8'h87 : 8'h12;
            end
            if (done === 1'b1) begin
                chk("cont bin_out", 32'(bin_out), ((nres % 2) == 0) ? 32'd12 : 32'd87);
                if (nres > 0) chk("cont period", 32'(c - last_done), 32'd9);
                last_done = c;
                nres++;
            end
        end
        start = 1'b0;
        chk("cont results", 32'(nres), 32'd3);
        tick();
        tick();

        // Asynchronous reset mid-SHIFT
        start  = 1'b1;
        bcd_in = 8'h56;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("async pre busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async busy", 32'(busy), 32'd0);
        chk("async done", 32'(done), 32'd0);
        chk("async bin_out", 32'(bin_out), 32'd0);
        chk("async err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        convert(8'h33, 33, 1'b0, 8, "after_reset33");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
